// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and field constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (S_IDLE, S_REQ, S_HOLD)
//   OP_W/FUNCT_W  : widths of the opcode and function fields
//   INSTR_W       : instruction / address width
//   *_LSB, IMM_W, TARGET_W : bit positions of the MIPS instruction fields
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam int OP_W      = 6;
    localparam int FUNCT_W   = 6;
    localparam int INSTR_W   = 32;

    localparam int OP_LSB    = 26;  // op     = instr[31:26]
    localparam int FUNCT_LSB = 0;   // funct  = instr[5:0]
    localparam int IMM_W     = 16;  // imm    = instr[15:0]
    localparam int TARGET_W  = 26;  // target = instr[25:0]

endpackage

// File: rtl/fetch_unit_next_pc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc_i32        in  current PC
//   instr_i32     in  instruction fetched at pc_i32
//   pc_branch_i   in  branch taken (already qualified by the controller)
//   pc_j_i        in  jump taken; has priority over pc_branch_i
//   pc_plus4_o32  out pc_i32 + 4 (mod 2^32)
//   next_pc_o32   out selected successor PC
// -----------------------------------------------------------------------------
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i32,
    input  logic [31:0] instr_i32,
    input  logic        pc_branch_i,
    input  logic        pc_j_i,
    output logic [31:0] pc_plus4_o32,
    output logic [31:0] next_pc_o32
);

    logic signed [INSTR_W-1:0] br_off;
    logic        [INSTR_W-1:0] br_target;
    logic        [INSTR_W-1:0] j_target;

    always_comb begin
        pc_plus4_o32 = pc_i32 + 32'd4;
        // Word offset: sign-extended immediate scaled by 4.
        br_off = $signed({{(INSTR_W-IMM_W-2){instr_i32[IMM_W-1]}},
                          instr_i32[IMM_W-1:0], 2'b00});
        br_target = pc_plus4_o32 + $unsigned(br_off);
        // Jump stays inside the 256 MB region of the delay-slot address.
        j_target  = {pc_plus4_o32[INSTR_W-1:TARGET_W+2],
                     instr_i32[TARGET_W-1:0], 2'b00};

        if (pc_j_i)
            next_pc_o32 = j_target;
        else if (pc_branch_i)
            next_pc_o32 = br_target;
        else
            next_pc_o32 = pc_plus4_o32;
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds the PC, fetches one word per instruction over
// a req/ack handshake, presents it to the controller and steps the PC when the
// instruction retires (S_HOLD with stall_i low).
// Optional feature: define FETCH_PERF_CNT_EN to add retire/stall counters.
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   imem_req_o, imem_addr_o32      fetch request and address (= PC)
//   imem_ack_i, imem_rdata_i32     memory accept, same-cycle instruction word
//   stall_i                        datapath hold of the presented instruction
//   pc_branch_i, pc_j_i            controller branch / jump decision
//   instr_o32, instr_valid_o       held instruction and its valid
//   op_o6, funct_o6                opcode and function fields
//   pc_o32, pc_plus4_o32           PC of held instruction and PC + 4
//   retired_cnt_o32, stall_cnt_o32 perf counters (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o32,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i32,
    input  logic        stall_i,
    input  logic        pc_branch_i,
    input  logic        pc_j_i,
    output logic [31:0] instr_o32,
    output logic        instr_valid_o,
    output logic [5:0]  op_o6,
    output logic [5:0]  funct_o6,
    output logic [31:0] pc_o32,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] retired_cnt_o32,
    output logic [31:0] stall_cnt_o32,
`endif
    output logic [31:0] pc_plus4_o32
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q;
    logic [31:0]        instr_q;
    logic [31:0]        next_pc;
    logic               latch_instr;
    logic               retire;

    next_pc_calc u_next_pc (
        .pc_i32       (pc_q),
        .instr_i32    (instr_q),
        .pc_branch_i  (pc_branch_i),
        .pc_j_i       (pc_j_i),
        .pc_plus4_o32 (pc_plus4_o32),
        .next_pc_o32  (next_pc)
    );

    // State, PC and instruction register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_instr)
                instr_q <= imem_rdata_i32;
            if (retire)
                pc_q <= next_pc;
        end
    end

    // Next state and handshake decode
    always_comb begin
        state_d       = state_q;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        latch_instr   = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    latch_instr = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid_o = 1'b1;
                if (!stall_i) begin
                    retire  = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr_o32 = pc_q;
    assign pc_o32        = pc_q;
    assign instr_o32     = instr_q;
    assign op_o6         = instr_q[OP_LSB +: OP_W];
    assign funct_o6      = instr_q[FUNCT_LSB +: FUNCT_W];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt_q;
    logic [31:0] stall_cnt_q;

    // Performance counters (wrap naturally at 2^32)
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (retire)
                retired_cnt_q <= retired_cnt_q + 32'd1;
            if (state_q == S_HOLD && stall_i)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign retired_cnt_o32 = retired_cnt_q;
    assign stall_cnt_o32   = stall_cnt_q;
`endif

endmodule
